// File: rtl/vga_scanout_if.sv
// Scanout bus: pixel strobe, framebuffer read port, VGA pins and frame tick.
interface vga_scanout_if #(
    parameter int CHANNEL_BITS = 4
);
    logic                    pixel_enable;
    logic [18:0]             ram_address;
    logic [2:0]              ram_read_data;
    logic [CHANNEL_BITS-1:0] vga_r;
    logic [CHANNEL_BITS-1:0] vga_g;
    logic [CHANNEL_BITS-1:0] vga_b;
    logic                    vga_hsync;
    logic                    vga_vsync;
    logic                    frame_start;

    modport master (
        input  pixel_enable, ram_read_data,
        output ram_address, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start
    );

    modport slave (
        output pixel_enable, ram_read_data,
        input  ram_address, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start
    );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 scanout of a 320x240x3 framebuffer, 2x2 pixel doubling; outputs lag the counters by 2 pixel_enable strobes.
// No backpressure: everything advances only on pixel_enable. Optional SCANLINES_EN blanks colour on odd output lines.
module vga_scanout #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int FB_WIDTH     = 320,
    parameter int CHANNEL_BITS = 4
) (
    input  logic          clock,
    input  logic          reset,
    vga_scanout_if.master bus
);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        h_wrap;
    logic        frame_wrap;
    logic        visible;
    logic        hsync_raw;
    logic        vsync_raw;
    logic [8:0]  fb_y;
    logic [18:0] row_base;
    logic [18:0] address_next;
    logic        visible_d;
    logic        hsync_d;
    logic        vsync_d;
    logic        blank;

    assign h_wrap     = (h_count == H_LAST);
    assign frame_wrap = h_wrap && (v_count == V_LAST);
    assign visible    = (h_count < H_VIS) && (v_count < V_VIS);
    assign hsync_raw  = !((h_count >= HS_BEGIN) && (h_count < HS_END));
    assign vsync_raw  = !((v_count >= VS_BEGIN) && (v_count < VS_END));

    // 320*y as two shifts; other strides fall back to a plain multiply.
    assign fb_y     = v_count[9:1];
    assign row_base = (FB_WIDTH == 320) ? (({10'd0, fb_y} << 8) + ({10'd0, fb_y} << 6))
                                        : 19'(32'(fb_y) * FB_WIDTH);
    assign address_next = visible ? (row_base + {10'd0, h_count[9:1]}) : 19'd0;

    assign bus.frame_start = bus.pixel_enable && frame_wrap && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= 10'd0;
            v_count <= 10'd0;
        end else if (bus.pixel_enable) begin
            if (h_wrap) begin
                h_count <= 10'd0;
                v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.ram_address <= 19'd0;
            visible_d       <= 1'b0;
            hsync_d         <= 1'b1;
            vsync_d         <= 1'b1;
        end else if (bus.pixel_enable) begin
            bus.ram_address <= address_next;
            visible_d       <= visible;
            hsync_d         <= hsync_raw;
            vsync_d         <= vsync_raw;
        end
    end

`ifdef SCANLINES_EN
    logic line_odd_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            line_odd_d <= 1'b0;
        end else if (bus.pixel_enable) begin
            line_odd_d <= v_count[0];
        end
    end

    assign blank = !visible_d || line_odd_d;
`else
    assign blank = !visible_d;
`endif

    // RAM data for the stage-1 address is valid here because strobes are >= 2 clocks apart.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.vga_r     <= '0;
            bus.vga_g     <= '0;
            bus.vga_b     <= '0;
            bus.vga_hsync <= 1'b1;
            bus.vga_vsync <= 1'b1;
        end else if (bus.pixel_enable) begin
            bus.vga_r     <= blank ? '0 : {CHANNEL_BITS{bus.ram_read_data[2]}};
            bus.vga_g     <= blank ? '0 : {CHANNEL_BITS{bus.ram_read_data[1]}};
            bus.vga_b     <= blank ? '0 : {CHANNEL_BITS{bus.ram_read_data[0]}};
            bus.vga_hsync <= hsync_d;
            bus.vga_vsync <= vsync_d;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout with a shortened vertical frame; the expected stream is derived from strobe index arithmetic.
module tb_vga_scanout;
    localparam int V_VIS = 8;
    localparam int V_FR  = 2;
    localparam int V_SY  = 2;
    localparam int V_BK  = 2;
    localparam int V_TOT = V_VIS + V_FR + V_SY + V_BK;
    localparam int H_TOT = 800;
    localparam int FRAME = H_TOT * V_TOT;

    typedef struct packed {
        logic        fs;
        logic [18:0] addr;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rst_q = 1'b0;

    vga_scanout_if #(.CHANNEL_BITS(4)) bus ();

    vga_scanout #(
        .V_VISIBLE(V_VIS),
        .V_FRONT(V_FR),
        .V_SYNC(V_SY),
        .V_BACK(V_BK),
        .CHANNEL_BITS(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    logic [2:0] fb [0:76799];
    exp_t       sb_q [$];
    int         checks = 0;
    int         errors = 0;
    int         strobe_n = 0;
    int         mon_n = 0;
    exp_t       cur;
    bit         pend = 1'b0;
    int         since = 0;

    always @(posedge clock) begin
        rst_q <= reset;
        bus.ram_read_data <= (bus.ram_address < 19'd76800) ? fb[bus.ram_address] : 3'd0;
    end

    // Expected frame_start and address during strobe n, and pin state right after it (position n-1).
    function automatic exp_t model(input int n);
        exp_t       e;
        int         h, v, m, hp, vp;
        logic [2:0] d;
        h      = n % H_TOT;
        v      = (n / H_TOT) % V_TOT;
        e.fs   = (h == H_TOT - 1) && (v == V_TOT - 1);
        e.addr = (h < 640 && v < V_VIS) ? 19'((v / 2) * 320 + h / 2) : 19'd0;
        e.rgb  = 12'd0;
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        if (n >= 1) begin
            m    = n - 1;
            hp   = m % H_TOT;
            vp   = (m / H_TOT) % V_TOT;
            e.hs = !(hp >= 656 && hp < 752);
            e.vs = !(vp >= V_VIS + V_FR && vp < V_VIS + V_FR + V_SY);
            d    = (hp < 640 && vp < V_VIS) ? fb[(vp / 2) * 320 + hp / 2] : 3'd0;
`ifdef SCANLINES_EN
            if (vp % 2 == 1) d = 3'd0;
`endif
            e.rgb = {{4{d[2]}}, {4{d[1]}}, {4{d[0]}}};
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s strobe=%0d got=%0h want=%0h", name, mon_n, got, want);
        end
    endtask

    task automatic strobe();
        @(posedge clock); #1;
        sb_q.push_back(model(strobe_n));
        strobe_n++;
        bus.pixel_enable = 1'b1;
        @(posedge clock); #1;
        bus.pixel_enable = 1'b0;
        if ($urandom_range(7) == 0) begin
            @(posedge clock); #1;
        end
    endtask

    // Monitor: frame_start is judged during the strobe clock, registered pins one clock later.
    initial begin
        forever begin
            @(negedge clock);
            if (pend) begin
                check("addr", 32'(bus.ram_address), 32'(cur.addr));
                check("rgb",  32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(cur.rgb));
                check("sync", 32'({bus.vga_hsync, bus.vga_vsync}), 32'({cur.hs, cur.vs}));
                pend = 1'b0;
            end
            if (rst_q) begin
                check("rst_addr", 32'(bus.ram_address), 32'd0);
                check("rst_rgb",  32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
                check("rst_sync", 32'({bus.vga_hsync, bus.vga_vsync}), 32'd3);
                since = 0;
                mon_n = 0;
            end
            if (bus.pixel_enable && !reset) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    cur = sb_q.pop_front();
                    check("frame_start", 32'(bus.frame_start), 32'(cur.fs));
                    pend = 1'b1;
                    since++;
                    mon_n++;
                    if (bus.frame_start) begin
                        check("frame_period", 32'(since), 32'(FRAME));
                        since = 0;
                    end
                end
            end else begin
                check("fs_idle", 32'(bus.frame_start), 32'd0);
            end
        end
    end

    initial begin
        bus.pixel_enable = 1'b0;
        for (int i = 0; i < 76800; i++) fb[i] = 3'($urandom);
        fb[641] = 3'b011;

        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            bus.pixel_enable = ~bus.pixel_enable;
        end
        @(posedge clock); #1;
        reset = 1'b0;
        bus.pixel_enable = 1'b0;

        // One full frame, then stop at h=300, v=3 and reset mid-frame.
        for (int i = 0; i < FRAME + 3 * H_TOT + 300; i++) strobe();
        @(posedge clock); #1;
        reset = 1'b1;
        bus.pixel_enable = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        bus.pixel_enable = 1'b0;
        strobe_n = 0;

        for (int i = 0; i < 2 * FRAME + 5; i++) strobe();
        repeat (4) @(posedge clock);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
